touch_key_multi_ctrl: RTL

Parametrised N-channel successor to the single touch-key LED toggler. Each channel does the following:
- synchronises a raw capacitive touch-key input;
- filters glitches over a programmable stable time;
- detects touch and long-press events;
- drives one LED according to a per-channel run-time mode (toggle, momentary, long-press toggle).

It sits between the board touch-key pins and the LED pins or a status register.

---
 rtl/touch_pkg.sv | 22 ++
 rtl/touch_key_chan.sv | 89 ++++++++
 rtl/touch_key_multi_ctrl.sv | 38 +++
 3 files changed

// File: rtl/touch_pkg.sv
// Shared definitions for the multi-channel touch-key controller: LED modes and
// a width helper for the per-channel counters.
package touch_pkg;

  localparam logic [1:0] MODE_TOGGLE      = 2'b00;
  localparam logic [1:0] MODE_MOMENTARY   = 2'b01;
  localparam logic [1:0] MODE_LONG_TOGGLE = 2'b10;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) begin
      w++;
    end
    if (w == 0) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/touch_key_chan.sv
// One touch-key channel: 2-flop synchroniser, glitch filter, long-press timer,
// event pulses and the mode-dependent LED latch.
module touch_key_chan
  import touch_pkg::*;
#(
  parameter int unsigned FILTER_CYC = 1_000_000,
  parameter int unsigned LONG_CYC   = 25_000_000,
  parameter logic        TOUCH_LVL  = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       touch_key,
  input  logic [1:0] mode,
  output logic       touched,
  output logic       press_pulse,
  output logic       long_pulse,
  output logic       led
);

  localparam int unsigned FW = clog2(FILTER_CYC);
  localparam int unsigned LW = clog2(LONG_CYC);

  logic          s1_q, s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          filt_dly_q;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          long_q, long_d;
  logic          latch_q, latch_d;
  logic          s2_touch;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_q       <= ~TOUCH_LVL;
      s2_q       <= ~TOUCH_LVL;
      filt_q     <= 1'b0;
      fcnt_q     <= '0;
      filt_dly_q <= 1'b0;
      lcnt_q     <= '0;
      long_q     <= 1'b0;
      latch_q    <= 1'b0;
    end else begin
      s1_q       <= touch_key;
      s2_q       <= s1_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      filt_dly_q <= filt_q;
      lcnt_q     <= lcnt_d;
      long_q     <= long_d;
      latch_q    <= latch_d;
    end
  end

  always_comb begin
    s2_touch = (s2_q == TOUCH_LVL);

    // Any cycle that agrees with the filtered state restarts the count.
    filt_d = filt_q;
    fcnt_d = '0;
    if (s2_touch != filt_q) begin
      if (fcnt_q == FW'(FILTER_CYC - 1)) begin
        filt_d = s2_touch;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    lcnt_d = '0;
    if (filt_q) begin
      lcnt_d = (lcnt_q == LW'(LONG_CYC - 1)) ? lcnt_q : lcnt_q + LW'(1);
    end
    // Registered so the pulse coincides with the counter reaching its ceiling.
    long_d = filt_q && (lcnt_q == LW'(LONG_CYC - 2));

    press_pulse = filt_q & ~filt_dly_q;
    long_pulse  = long_q;
    touched     = filt_q;

    latch_d = latch_q;
    case (mode)
      MODE_MOMENTARY:   latch_d = latch_q;
      MODE_LONG_TOGGLE: latch_d = latch_q ^ long_q;
      default:          latch_d = latch_q ^ press_pulse;
    endcase

    led = (mode == MODE_MOMENTARY) ? filt_q : latch_q;
  end

endmodule

// File: rtl/touch_key_multi_ctrl.sv
// N independent touch-key channels, each driving one LED in a run-time
// selectable mode.
module touch_key_multi_ctrl
  import touch_pkg::*;
#(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned FILTER_CYC = 1_000_000,
  parameter int unsigned LONG_CYC   = 25_000_000,
  parameter logic        TOUCH_LVL  = 1'b0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [CH_NUM-1:0]   touch_key,
  input  logic [2*CH_NUM-1:0] mode,
  output logic [CH_NUM-1:0]   touched,
  output logic [CH_NUM-1:0]   press_pulse,
  output logic [CH_NUM-1:0]   long_pulse,
  output logic [CH_NUM-1:0]   led
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
    touch_key_chan #(
      .FILTER_CYC (FILTER_CYC),
      .LONG_CYC   (LONG_CYC),
      .TOUCH_LVL  (TOUCH_LVL)
    ) u_chan (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .touch_key   (touch_key[i]),
      .mode        (mode[2*i +: 2]),
      .touched     (touched[i]),
      .press_pulse (press_pulse[i]),
      .long_pulse  (long_pulse[i]),
      .led         (led[i])
    );
  end

endmodule
